adc_deviation_meter: RTL and testbench

Parametrised deviation meter for the ADC front end. It averages 2^AVG_LOG2 ADC samples per window and computes the signed deviation of the average from a configurable centre code, applying a deadband. The result drives the LED bank as either a scaled magnitude or a directional bar graph, with a side indicator. It sits between `adc_control`'s channel output (plus a sample-valid strobe) and the board LEDs.

---
 rtl/adc_deviation_meter.sv | 166 ++++++++++++++++
 tb/tb_adc_deviation_meter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/adc_deviation_meter.sv
// rtl/adc_deviation_meter.sv - windowed ADC average, deviation from centre, LED magnitude/bar display
// Optional peak hold on the magnitude display: define PEAK_HOLD_EN.
module adc_deviation_meter #(
  parameter int DATA_W       = 12,
  parameter int LED_W        = 8,
  parameter int AVG_LOG2     = 2,
  parameter int CENTER       = 2048,
  parameter int DEADBAND     = 16,
  parameter int HOLD_UPDATES = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] SAMPLE_IN,
  input  logic              SAMPLE_VALID,
  input  logic              MODE,
  output logic [LED_W-1:0]  LED,
  output logic [1:0]        DIR,
  output logic              UPDATE,
  output logic              OVERRUN
);

  localparam int ACC_W      = DATA_W + AVG_LOG2;
  localparam int CNT_W      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int MAG_W      = DATA_W + 1;
  localparam int LIT_W      = $clog2(LED_W + 1);
  localparam int PROD_W     = MAG_W + LIT_W;
  localparam int LVL_SHIFT  = DATA_W - 1 - LED_W;
  localparam int BAR_SHIFT  = DATA_W - 1;

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [MAG_W-1:0]  CENTER_X   = MAG_W'(CENTER);
  localparam logic [MAG_W-1:0]  DEADBAND_X = MAG_W'(DEADBAND);
  localparam logic [MAG_W-1:0]  LED_MAX_X  = MAG_W'((1 << LED_W) - 1);
  localparam logic [PROD_W-1:0] LED_W_X    = PROD_W'(LED_W);
  localparam logic [LIT_W-1:0]  LIT_MAX    = LIT_W'(LED_W);
  localparam logic [LED_W-1:0]  ALL_ONES   = {LED_W{1'b1}};

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_ABOVE = 2'b01;
  localparam logic [1:0] DIR_BELOW = 2'b10;

  logic [1:0]        state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [MAG_W-1:0]  mag_r;
  logic [1:0]        dir_r;

  logic [DATA_W-1:0] avg;
  logic [MAG_W-1:0]  dev;
  logic [MAG_W-1:0]  abs_dev;
  logic [MAG_W-1:0]  calc_mag;
  logic [1:0]        calc_dir;

  logic [MAG_W-1:0]  lvl_shifted;
  logic [LED_W-1:0]  level;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] lit_raw;
  logic [LIT_W-1:0]  lit;
  logic [LED_W-1:0]  bar;
  logic [LED_W-1:0]  shown;

  // Deviation is formed in DATA_W+1 bit two's complement so both sides of centre fit.
  always_comb begin
    avg      = acc[ACC_W-1:AVG_LOG2];
    dev      = {1'b0, avg} - CENTER_X;
    abs_dev  = dev[MAG_W-1] ? (MAG_W'(0) - dev) : dev;
    calc_mag = abs_dev;
    calc_dir = dev[MAG_W-1] ? DIR_BELOW : DIR_ABOVE;
    if (abs_dev <= DEADBAND_X) begin
      calc_mag = '0;
      calc_dir = DIR_NONE;
    end
  end

  always_comb begin
    lvl_shifted = mag_r >> LVL_SHIFT;
    level       = (lvl_shifted > LED_MAX_X) ? LED_MAX_X[LED_W-1:0] : lvl_shifted[LED_W-1:0];
    prod        = PROD_W'(mag_r) * LED_W_X;
    lit_raw     = prod >> BAR_SHIFT;
    lit         = (lit_raw > LED_W_X) ? LIT_MAX : lit_raw[LIT_W-1:0];
    // Above-centre bars grow from bit 0, below-centre bars grow from the MSB.
    bar = '0;
    if (dir_r == DIR_ABOVE)
      bar = ~(ALL_ONES << lit);
    else if (dir_r == DIR_BELOW)
      bar = ~(ALL_ONES >> lit);
  end

`ifdef PEAK_HOLD_EN
  localparam int HOLD_W = (HOLD_UPDATES > 1) ? $clog2(HOLD_UPDATES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_UPDATES - 1);

  logic [LED_W-1:0]  peak;
  logic [HOLD_W-1:0] hold_cnt;

  assign shown = (level > peak) ? level : peak;

  // The displayed value uses the peak from before this update; the decay takes effect next time.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      peak     <= '0;
      hold_cnt <= '0;
    end else if (state == ST_OUT) begin
      if (level > peak) begin
        peak     <= level;
        hold_cnt <= '0;
      end else if (hold_cnt == HOLD_LAST) begin
        peak     <= level;
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end
`else
  assign shown = level;
`endif

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state   <= ST_ACCUM;
      acc     <= '0;
      cnt     <= '0;
      mag_r   <= '0;
      dir_r   <= DIR_NONE;
      LED     <= '0;
      DIR     <= DIR_NONE;
      UPDATE  <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      UPDATE <= 1'b0;
      if (state != ST_ACCUM && SAMPLE_VALID)
        OVERRUN <= 1'b1;
      case (state)
        ST_ACCUM: begin
          if (SAMPLE_VALID) begin
            acc <= acc + ACC_W'(SAMPLE_IN);
            if (cnt == CNT_LAST)
              state <= ST_CALC;
            else
              cnt <= cnt + CNT_W'(1);
          end
        end
        ST_CALC: begin
          mag_r <= calc_mag;
          dir_r <= calc_dir;
          acc   <= '0;
          cnt   <= '0;
          state <= ST_OUT;
        end
        ST_OUT: begin
          LED    <= MODE ? bar : shown;
          DIR    <= dir_r;
          UPDATE <= 1'b1;
          state  <= ST_ACCUM;
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_deviation_meter.sv
// tb/tb_adc_deviation_meter.sv - scoreboard bench for adc_deviation_meter with default parameters
module tb_adc_deviation_meter;

  logic        CLOCK;
  logic        RESET;
  logic [11:0] SAMPLE_IN;
  logic        SAMPLE_VALID;
  logic        MODE;
  logic [7:0]  LED;
  logic [1:0]  DIR;
  logic        UPDATE;
  logic        OVERRUN;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_cap = 0;

  typedef struct {
    logic [7:0] led;
    logic [1:0] dir;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  adc_deviation_meter dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .SAMPLE_IN(SAMPLE_IN),
    .SAMPLE_VALID(SAMPLE_VALID),
    .MODE(MODE),
    .LED(LED),
    .DIR(DIR),
    .UPDATE(UPDATE),
    .OVERRUN(OVERRUN)
  );

  initial CLOCK = 1'b0;
  always #10 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Monitor: every UPDATE pulse must match the oldest expected result, at the expected edge.
  always @(negedge CLOCK) begin
    if (!RESET && UPDATE) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_update: LED=%h DIR=%b, no update expected", LED, DIR);
      end else begin
        mon_e = exp_q.pop_front();
        if (LED !== mon_e.led || DIR !== mon_e.dir) begin
          n_bad++;
          $display("FAIL update_value: got LED=%h DIR=%b, want LED=%h DIR=%b",
                   LED, DIR, mon_e.led, mon_e.dir);
        end
        n_cmp++;
        if (cyc != mon_e.cyc) begin
          n_bad++;
          $display("FAIL update_latency: got edge %0d, want edge %0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic send(input logic [11:0] s);
    SAMPLE_IN    = s;
    SAMPLE_VALID = 1'b1;
    @(posedge CLOCK);
    #1;
    last_cap     = cyc;
    SAMPLE_VALID = 1'b0;
  endtask

  task automatic window(input logic [11:0] a, input logic [11:0] b,
                        input logic [11:0] c, input logic [11:0] d,
                        input logic mode, input logic [7:0] led,
                        input logic [1:0] dir, input bit extra);
    exp_t e;
    MODE = mode;
    send(a);
    send(b);
    send(c);
    send(d);
    e.led = led;
    e.dir = dir;
    e.cyc = last_cap + 2;
    exp_q.push_back(e);
    if (extra) begin
      send(12'hABC);
      idle(1);
    end else begin
      idle(2);
    end
  endtask

  initial begin
    RESET        = 1'b1;
    SAMPLE_IN    = '0;
    SAMPLE_VALID = 1'b0;
    MODE         = 1'b0;
    idle(3);
    check("reset_led", 16'(LED), 16'h00);
    check("reset_dir", 16'(DIR), 16'h0);
    check("reset_update", 16'(UPDATE), 16'h0);
    check("reset_overrun", 16'(OVERRUN), 16'h0);
    RESET = 1'b0;
    idle(2);

`ifdef PEAK_HOLD_EN
    window(4095, 4095, 4095, 4095, 1'b0, 8'hFF, 2'b01, 1'b0);
    for (int k = 0; k < 16; k++)
      window(2048, 2048, 2048, 2048, 1'b0, 8'hFF, 2'b00, 1'b0);
    window(2048, 2048, 2048, 2048, 1'b0, 8'h00, 2'b00, 1'b0);
    window(0, 0, 0, 0, 1'b1, 8'hFF, 2'b10, 1'b0);
`else
    window(0, 0, 0, 0, 1'b1, 8'hFF, 2'b10, 1'b0);
    window(2048, 2048, 2048, 2048, 1'b0, 8'h00, 2'b00, 1'b0);
    window(2060, 2060, 2060, 2060, 1'b0, 8'h00, 2'b00, 1'b0);
    window(2064, 2064, 2064, 2064, 1'b0, 8'h00, 2'b00, 1'b0);
    window(2065, 2065, 2065, 2065, 1'b0, 8'h02, 2'b01, 1'b0);
    window(1000, 1000, 1000, 1004, 1'b0, 8'h82, 2'b10, 1'b0);
    window(3072, 3072, 3072, 3072, 1'b1, 8'h0F, 2'b01, 1'b0);
    window(1024, 1024, 1024, 1024, 1'b1, 8'hF0, 2'b10, 1'b0);
    window(1800, 1800, 1800, 1800, 1'b1, 8'h00, 2'b10, 1'b0);
    window(4095, 4095, 4095, 4095, 1'b1, 8'h7F, 2'b01, 1'b0);
    window(0, 0, 0, 0, 1'b0, 8'hFF, 2'b10, 1'b0);
    check("overrun_clear_before", 16'(OVERRUN), 16'h0);

    window(3000, 3000, 3000, 3000, 1'b0, 8'h77, 2'b01, 1'b1);
    check("overrun_set", 16'(OVERRUN), 16'h1);
    window(1500, 1500, 1500, 1500, 1'b0, 8'h44, 2'b10, 1'b0);
    check("overrun_sticky", 16'(OVERRUN), 16'h1);

    // Reset with half a window accumulated; the leftover samples must not count.
    send(100);
    send(200);
    RESET = 1'b1;
    #1;
    check("midreset_led", 16'(LED), 16'h00);
    check("midreset_dir", 16'(DIR), 16'h0);
    check("midreset_overrun", 16'(OVERRUN), 16'h0);
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    idle(1);
    window(4095, 4095, 4095, 4095, 1'b0, 8'hFF, 2'b01, 1'b0);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      idle(1);
    idle(4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_updates: %0d outstanding, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
